// File: rtl/ysyx_25040109_memctl_pkg.sv
// Shared types and constants for the ysyx_25040109 memory controller.
// State and request-source enums, plus the store-length encodings that the
// core places on dmem_wlen.
package ysyx_25040109_memctl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    ISSUE = 2'd2,
    DATA  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    SRC_IMEM   = 2'd0,
    SRC_DLOAD  = 2'd1,
    SRC_DSTORE = 2'd2
  } src_t;

  localparam logic [2:0] WLEN_B = 3'd1;
  localparam logic [2:0] WLEN_H = 3'd2;
  localparam logic [2:0] WLEN_W = 3'd4;

endpackage

// File: rtl/ysyx_25040109_memctl_wstrb.sv
// Store lane steering for the memory controller (purely combinational).
// Turns a right-aligned store (byte offset, byte count, data) into the
// byte-enable mask and lane-shifted data seen by a 32-bit word memory.
//   off        in  2   byte offset of the store address (addr[1:0])
//   wlen       in  3   store byte count: 1, 2 or 4
//   wdata      in  32  right-aligned store data
//   wstrb      out 4   byte enables
//   lane_wdata out 32  store data moved onto its byte lanes
module ysyx_25040109_memctl_wstrb
  import ysyx_25040109_memctl_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [2:0]  wlen,
  input  logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic [31:0] lane_wdata
);

  // Unsupported lengths produce an empty mask so the access is harmless
  // but still completes, keeping the core from waiting forever.
  always_comb begin
    wstrb      = 4'b0000;
    lane_wdata = wdata;
    case (wlen)
      WLEN_B: begin
        wstrb      = 4'b0001 << off;
        lane_wdata = wdata << {off, 3'b000};
      end
      WLEN_H: begin
        wstrb      = 4'b0011 << {off[1], 1'b0};
        lane_wdata = wdata << {off[1], 4'b0000};
      end
      WLEN_W: begin
        wstrb = 4'hF;
      end
      default: begin
        wstrb = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/ysyx_25040109_memctl.sv
// Memory controller between the single-cycle core and a single-port
// backing memory with 1-cycle read latency. Fetch, load and store requests
// are arbitrated (store > load > fetch), optionally delayed by LATENCY
// cycles, issued one at a time, and answered with a one-cycle pulse.
//   LATENCY     param     extra wait cycles before each access (0..255)
//   clk, rst    in        clock, asynchronous active-high reset
//   imem_*      in/out    fetch channel: addr, ren -> rdata, rvalid
//   dmem_r*     in/out    load channel: raddr, ren -> rdata, rvalid
//   dmem_w*     in/out    store channel: waddr, wdata, wlen, wen -> wready
//   mem_*       out/in    backing memory: valid, we, addr, wdata, wstrb; rdata
module ysyx_25040109_memctl
  import ysyx_25040109_memctl_pkg::*;
#(
  parameter int LATENCY = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] imem_addr,
  input  logic        imem_ren,
  output logic [31:0] imem_rdata,
  output logic        imem_rvalid,
  input  logic [31:0] dmem_raddr,
  input  logic        dmem_ren,
  output logic [31:0] dmem_rdata,
  output logic        dmem_rvalid,
  input  logic [31:0] dmem_waddr,
  input  logic [31:0] dmem_wdata,
  input  logic [2:0]  dmem_wlen,
  input  logic        dmem_wen,
  output logic        dmem_wready,
  output logic        mem_valid,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata
);

  localparam logic [7:0] LAT_M1 = (LATENCY > 0) ? 8'(LATENCY - 1) : 8'd0;

  state_t      state;
  state_t      state_next;
  logic [7:0]  cnt;
  logic [7:0]  cnt_next;
  logic        accept;
  src_t        accept_src;
  logic [31:0] accept_addr;

  src_t        cap_src;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;
  logic [3:0]  cap_wstrb;

  logic [3:0]  lane_wstrb;
  logic [31:0] lane_wdata;
  logic [31:0] imem_rdata_q;
  logic [31:0] dmem_rdata_q;
  logic        issue;
  logic        respond;

  ysyx_25040109_memctl_wstrb u_wstrb (
    .off        (dmem_waddr[1:0]),
    .wlen       (dmem_wlen),
    .wdata      (dmem_wdata),
    .wstrb      (lane_wstrb),
    .lane_wdata (lane_wdata)
  );

  // State and wait counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 8'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Arbitration and sequencing. With LATENCY=0 the DELAY state is skipped.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    accept      = 1'b0;
    accept_src  = SRC_IMEM;
    accept_addr = imem_addr;
    case (state)
      IDLE: begin
        if (dmem_wen) begin
          accept      = 1'b1;
          accept_src  = SRC_DSTORE;
          accept_addr = dmem_waddr;
        end else if (dmem_ren) begin
          accept      = 1'b1;
          accept_src  = SRC_DLOAD;
          accept_addr = dmem_raddr;
        end else if (imem_ren) begin
          accept      = 1'b1;
          accept_src  = SRC_IMEM;
          accept_addr = imem_addr;
        end
        if (accept) begin
          if (LATENCY == 0) begin
            state_next = ISSUE;
          end else begin
            state_next = DELAY;
            cnt_next   = LAT_M1;
          end
        end
      end
      DELAY: begin
        if (cnt == 8'd0) begin
          state_next = ISSUE;
        end else begin
          cnt_next = cnt - 8'd1;
        end
      end
      ISSUE:   state_next = DATA;
      DATA:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request capture; later changes on the request inputs are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_src   <= SRC_IMEM;
      cap_addr  <= 32'd0;
      cap_wdata <= 32'd0;
      cap_wstrb <= 4'd0;
    end else if (accept) begin
      cap_src  <= accept_src;
      cap_addr <= accept_addr & 32'hFFFF_FFFC;
      if (accept_src == SRC_DSTORE) begin
        cap_wdata <= lane_wdata;
        cap_wstrb <= lane_wstrb;
      end else begin
        cap_wdata <= 32'd0;
        cap_wstrb <= 4'd0;
      end
    end
  end

  assign issue   = (state == ISSUE);
  assign respond = (state == DATA);

  // Memory-side outputs are forced to zero outside ISSUE so that reset
  // clears them immediately.
  assign mem_valid = issue;
  assign mem_we    = issue && (cap_src == SRC_DSTORE);
  assign mem_addr  = issue ? cap_addr  : 32'd0;
  assign mem_wdata = issue ? cap_wdata : 32'd0;
  assign mem_wstrb = issue ? cap_wstrb : 4'd0;

  assign imem_rvalid = respond && (cap_src == SRC_IMEM);
  assign dmem_rvalid = respond && (cap_src == SRC_DLOAD);
  assign dmem_wready = respond && (cap_src == SRC_DSTORE);

  // Last returned word per read channel. The memory's data only arrives in
  // the response cycle, so it is forwarded then and held afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      imem_rdata_q <= 32'd0;
      dmem_rdata_q <= 32'd0;
    end else begin
      if (imem_rvalid) imem_rdata_q <= mem_rdata;
      if (dmem_rvalid) dmem_rdata_q <= mem_rdata;
    end
  end

  assign imem_rdata = imem_rvalid ? mem_rdata : imem_rdata_q;
  assign dmem_rdata = dmem_rvalid ? mem_rdata : dmem_rdata_q;

endmodule

// File: tb/tb_ysyx_25040109_memctl.sv
// Self-checking bench for ysyx_25040109_memctl: a LATENCY=3 instance driven
// by a directed vector table, hand sequences and random requests, and a
// LATENCY=0 instance for the back-to-back fetch timing.
module tb_ysyx_25040109_memctl;

  localparam int L = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] imem_addr = '0, dmem_raddr = '0, dmem_waddr = '0, dmem_wdata = '0;
  logic        imem_ren = 1'b0, dmem_ren = 1'b0, dmem_wen = 1'b0;
  logic [2:0]  dmem_wlen = '0;
  logic [31:0] imem_rdata, dmem_rdata, mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        imem_rvalid, dmem_rvalid, dmem_wready, mem_valid, mem_we;
  logic [3:0]  mem_wstrb;

  logic        z_rst = 1'b1;
  logic [31:0] z_imem_rdata, z_dmem_rdata, z_mem_addr, z_mem_wdata;
  logic        z_imem_rvalid, z_dmem_rvalid, z_dmem_wready, z_mem_valid, z_mem_we;
  logic [3:0]  z_mem_wstrb;

  int checks = 0;
  int failures = 0;
  logic [31:0] last_i = '0, last_d = '0;
  logic [31:0] mem_model [logic [31:0]];

  typedef struct {
    logic wen; logic ren; logic iren;
    logic [31:0] waddr; logic [31:0] wdata; logic [2:0] wlen;
    logic [31:0] raddr; logic [31:0] iaddr;
    int exp_src;             // 0 none, 1 fetch, 2 load, 3 store
    logic [31:0] exp_addr; logic [3:0] exp_strb; logic [31:0] exp_wdata;
    bit chk_wdata; logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [12];

  ysyx_25040109_memctl #(.LATENCY(L)) dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_ren(imem_ren), .imem_rdata(imem_rdata), .imem_rvalid(imem_rvalid),
    .dmem_raddr(dmem_raddr), .dmem_ren(dmem_ren), .dmem_rdata(dmem_rdata), .dmem_rvalid(dmem_rvalid),
    .dmem_waddr(dmem_waddr), .dmem_wdata(dmem_wdata), .dmem_wlen(dmem_wlen), .dmem_wen(dmem_wen),
    .dmem_wready(dmem_wready), .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
  );

  ysyx_25040109_memctl #(.LATENCY(0)) dut_z (
    .clk(clk), .rst(z_rst),
    .imem_addr(32'h8000_0000), .imem_ren(1'b1), .imem_rdata(z_imem_rdata), .imem_rvalid(z_imem_rvalid),
    .dmem_raddr(32'h0), .dmem_ren(1'b0), .dmem_rdata(z_dmem_rdata), .dmem_rvalid(z_dmem_rvalid),
    .dmem_waddr(32'h0), .dmem_wdata(32'h0), .dmem_wlen(3'd0), .dmem_wen(1'b0),
    .dmem_wready(z_dmem_wready), .mem_valid(z_mem_valid), .mem_we(z_mem_we), .mem_addr(z_mem_addr),
    .mem_wdata(z_mem_wdata), .mem_wstrb(z_mem_wstrb), .mem_rdata(32'h0000_0413)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return a ^ 32'hA5A5_0F0F;
  endfunction

  // Backing memory: writes merge by byte enable, reads answer next cycle.
  always @(posedge clk) begin : backing_mem
    logic [31:0] word;
    if (mem_valid) begin
      if (mem_we) begin
        word = mem_rd(mem_addr);
        for (int i = 0; i < 4; i++)
          if (mem_wstrb[i]) word[8*i +: 8] = mem_wdata[8*i +: 8];
        mem_model[mem_addr] = word;
      end else begin
        mem_rdata <= mem_rd(mem_addr);
      end
    end
  end

  // Reference model: priority pick, then byte-range view of the store.
  function automatic vec_t predict(input vec_t v);
    vec_t r;
    logic [31:0] a;
    int off, base, len;
    r = v;
    r.exp_src = 0; r.exp_strb = '0; r.exp_wdata = '0; r.chk_wdata = 0; r.exp_rdata = '0;
    a = '0;
    if (v.wen) begin r.exp_src = 3; a = v.waddr; end
    else if (v.ren) begin r.exp_src = 2; a = v.raddr; end
    else if (v.iren) begin r.exp_src = 1; a = v.iaddr; end
    r.exp_addr = a - (a % 4);
    if (r.exp_src == 3) begin
      off = int'(v.waddr % 4);
      len = int'(v.wlen);
      if (len == 1) base = off;
      else if (len == 2) base = (off / 2) * 2;
      else if (len == 4) base = 0;
      else begin base = 0; len = 0; end
      r.chk_wdata = (len != 0);
      for (int i = 0; i < 4; i++) begin
        if (i >= base && i < base + len) r.exp_strb[i] = 1'b1;
        if (i >= base) r.exp_wdata[8*i +: 8] = v.wdata[8*(i-base) +: 8];
      end
    end else if (r.exp_src != 0) begin
      r.exp_rdata = mem_rd(r.exp_addr);
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    dmem_wen = v.wen; dmem_ren = v.ren; imem_ren = v.iren;
    dmem_waddr = v.waddr; dmem_wdata = v.wdata; dmem_wlen = v.wlen;
    dmem_raddr = v.raddr; imem_addr = v.iaddr;
  endtask

  task automatic scramble();
    dmem_wen = 1'b0; dmem_ren = 1'b0; imem_ren = 1'b0;
    dmem_waddr = $urandom; dmem_wdata = $urandom; dmem_wlen = 3'($urandom_range(0, 7));
    dmem_raddr = $urandom; imem_addr = $urandom;
  endtask

  // One transaction: requests visible in cycle 0, then withdrawn and
  // scrambled; everything observed up to cycle L+2 is checked.
  task automatic runTxn(input vec_t v, input string name);
    int mv_count = 0, mv_cyc = -1, resp_cyc = -1, total = 0;
    int resp_cnt [4] = '{0, 0, 0, 0};
    logic [31:0] g_addr = '0, g_wdata = '0, g_ir = '0, g_dr = '0;
    logic [3:0] g_strb = '0;
    logic g_we = 1'b0;
    for (int c = 0; c <= L + 2; c++) begin
      @(posedge clk); #1;
      if (c == 0) applyStimulus(v);
      if (c == 1) scramble();
      @(negedge clk);
      if (mem_valid) begin
        if (mv_count == 0) begin
          mv_cyc = c; g_addr = mem_addr; g_wdata = mem_wdata; g_strb = mem_wstrb; g_we = mem_we;
        end
        mv_count++;
      end
      if (imem_rvalid) begin resp_cnt[1]++; total++; resp_cyc = c; end
      if (dmem_rvalid) begin resp_cnt[2]++; total++; resp_cyc = c; end
      if (dmem_wready) begin resp_cnt[3]++; total++; resp_cyc = c; end
      if (c == L + 2) begin g_ir = imem_rdata; g_dr = dmem_rdata; end
    end
    if (v.exp_src == 0) begin
      checkOutput({name, " idle_mem_valid"}, mv_count, 0);
      checkOutput({name, " idle_resp"}, total, 0);
    end else begin
      checkOutput({name, " mv_cycle"}, mv_cyc, L + 1);
      checkOutput({name, " mv_count"}, mv_count, 1);
      checkOutput({name, " mem_addr"}, g_addr, v.exp_addr);
      checkOutput({name, " mem_we"}, {31'b0, g_we}, (v.exp_src == 3) ? 1 : 0);
      if (v.exp_src == 3) checkOutput({name, " mem_wstrb"}, {28'b0, g_strb}, {28'b0, v.exp_strb});
      if (v.chk_wdata) checkOutput({name, " mem_wdata"}, g_wdata, v.exp_wdata);
      checkOutput({name, " resp_count"}, resp_cnt[v.exp_src], 1);
      checkOutput({name, " resp_cycle"}, resp_cyc, L + 2);
      checkOutput({name, " stray_resp"}, total - resp_cnt[v.exp_src], 0);
      if (v.exp_src == 1) last_i = v.exp_rdata;
      if (v.exp_src == 2) last_d = v.exp_rdata;
      checkOutput({name, " imem_rdata"}, g_ir, last_i);
      checkOutput({name, " dmem_rdata"}, g_dr, last_d);
    end
  endtask

  function automatic logic any_out();
    return |{imem_rdata, imem_rvalid, dmem_rdata, dmem_rvalid, dmem_wready,
             mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb};
  endfunction

  initial begin
    vec_t v;
    int mv_bits, rv_bits, w_cyc, r_cyc, i_cyc, w_n, r_n, i_n, multi, seen;
    logic [31:0] z_rd, z_ad, r_data, i_data, exp_i;
    logic [2:0] wl_pick [8];

    // wen ren iren waddr wdata wlen raddr iaddr | src addr strb wdata chk rdata
    vecs[0]  = '{0,1,0, 32'h0, 32'h0, 3'd0, 32'h8000_1004, 32'h0, 2, 32'h8000_1004, 4'h0, 32'h0, 0, 32'h25A5_1F0B};
    vecs[1]  = '{1,0,0, 32'h8000_0003, 32'h0000_00AB, 3'd1, 32'h0, 32'h0, 3, 32'h8000_0000, 4'b1000, 32'hAB00_0000, 1, 32'h0};
    vecs[2]  = '{1,0,0, 32'h8000_0002, 32'h0000_1234, 3'd2, 32'h0, 32'h0, 3, 32'h8000_0000, 4'b1100, 32'h1234_0000, 1, 32'h0};
    vecs[3]  = '{1,0,0, 32'h8000_0010, 32'hDEAD_BEEF, 3'd3, 32'h0, 32'h0, 3, 32'h8000_0010, 4'b0000, 32'h0, 0, 32'h0};
    vecs[4]  = '{1,0,0, 32'h8000_000A, 32'hCAFE_F00D, 3'd4, 32'h0, 32'h0, 3, 32'h8000_0008, 4'hF, 32'hCAFE_F00D, 1, 32'h0};
    vecs[5]  = '{0,0,1, 32'h0, 32'h0, 3'd0, 32'h0, 32'h8000_0000, 1, 32'h8000_0000, 4'h0, 32'h0, 0, 32'h1234_0F0F};
    vecs[6]  = '{1,0,1, 32'h8000_0001, 32'h1234_56CD, 3'd1, 32'h0, 32'h8000_0040, 3, 32'h8000_0000, 4'b0010, 32'h3456_CD00, 1, 32'h0};
    vecs[7]  = '{0,1,1, 32'h0, 32'h0, 3'd0, 32'h8000_0006, 32'h8000_0040, 2, 32'h8000_0004, 4'h0, 32'h0, 0, 32'h25A5_0F0B};
    vecs[8]  = '{1,0,0, 32'h8000_0021, 32'hFFFF_5678, 3'd2, 32'h0, 32'h0, 3, 32'h8000_0020, 4'b0011, 32'hFFFF_5678, 1, 32'h0};
    vecs[9]  = '{0,1,0, 32'h0, 32'h0, 3'd0, 32'h8000_0002, 32'h0, 2, 32'h8000_0000, 4'h0, 32'h0, 0, 32'h1234_CD0F};
    vecs[10] = '{0,1,0, 32'h0, 32'h0, 3'd0, 32'h8000_000B, 32'h0, 2, 32'h8000_0008, 4'h0, 32'h0, 0, 32'hCAFE_F00D};
    vecs[11] = '{0,0,1, 32'h0, 32'h0, 3'd0, 32'h0, 32'h8000_0020, 1, 32'h8000_0020, 4'h0, 32'h0, 0, 32'h25A5_5678};

    #2;
    checkOutput("reset_outputs", {31'b0, any_out()}, 32'h0);
    checkOutput("reset_mem_valid_z", {31'b0, z_mem_valid}, 32'h0);

    // LATENCY=0 instance: fetches back to back from cycle 0.
    mv_bits = 0; rv_bits = 0; z_rd = '0; z_ad = '0;
    @(posedge clk); #1 z_rst = 1'b0;
    for (int c = 0; c <= 4; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      @(negedge clk);
      if (z_mem_valid) mv_bits |= (1 << c);
      if (z_imem_rvalid) rv_bits |= (1 << c);
      if (c == 1) z_ad = z_mem_addr;
      if (c == 2) z_rd = z_imem_rdata;
    end
    checkOutput("lat0 mem_valid_cycles", mv_bits, 32'b10010);
    checkOutput("lat0 rvalid_cycles", rv_bits, 32'b00100);
    checkOutput("lat0 mem_addr", z_ad, 32'h8000_0000);
    checkOutput("lat0 imem_rdata", z_rd, 32'h0000_0413);

    @(negedge clk) rst = 1'b0;
    for (int k = 0; k < 12; k++) runTxn(vecs[k], $sformatf("vec%0d", k));

    // Store, load and fetch requested together and held until answered.
    exp_i = mem_rd(32'h8000_0034);
    w_n = 0; r_n = 0; i_n = 0; multi = 0; w_cyc = -1; r_cyc = -1; i_cyc = -1;
    r_data = '0; i_data = '0;
    for (int c = 0; c <= 3 * L + 8; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        dmem_wen = 1'b1; dmem_waddr = 32'h8000_0030; dmem_wdata = 32'h1122_3344; dmem_wlen = 3'd4;
        dmem_ren = 1'b1; dmem_raddr = 32'h8000_0030;
        imem_ren = 1'b1; imem_addr = 32'h8000_0034;
      end
      if (w_n > 0) dmem_wen = 1'b0;
      if (r_n > 0) dmem_ren = 1'b0;
      if (i_n > 0) imem_ren = 1'b0;
      @(negedge clk);
      seen = int'(dmem_wready) + int'(dmem_rvalid) + int'(imem_rvalid);
      if (seen > 1) multi++;
      if (dmem_wready) begin w_n++; w_cyc = c; end
      if (dmem_rvalid) begin r_n++; r_cyc = c; r_data = dmem_rdata; end
      if (imem_rvalid) begin i_n++; i_cyc = c; i_data = imem_rdata; end
    end
    @(posedge clk); #1 scramble();
    checkOutput("all3 store_cycle", w_cyc, L + 2);
    checkOutput("all3 load_cycle", r_cyc, 2 * L + 5);
    checkOutput("all3 fetch_cycle", i_cyc, 3 * L + 8);
    checkOutput("all3 pulse_counts", {w_n[7:0], r_n[7:0], i_n[7:0], multi[7:0]}, 32'h0101_0100);
    checkOutput("all3 load_data", r_data, 32'h1122_3344);
    checkOutput("all3 fetch_data", i_data, exp_i);
    last_d = 32'h1122_3344; last_i = exp_i;

    // Asynchronous reset while a load sits in DELAY.
    @(posedge clk); #1 dmem_ren = 1'b1; dmem_raddr = 32'h8000_0008;
    @(posedge clk); #1 dmem_ren = 1'b0;
    @(posedge clk); #2 rst = 1'b1;
    #1 checkOutput("async_reset_outputs", {31'b0, any_out()}, 32'h0);
    @(posedge clk); @(negedge clk) rst = 1'b0;
    last_i = '0; last_d = '0;
    seen = 0;
    for (int c = 0; c < L + 4; c++) begin
      @(negedge clk);
      if (mem_valid || imem_rvalid || dmem_rvalid || dmem_wready) seen++;
    end
    checkOutput("post_reset_silence", seen, 0);
    v = '{0,1,0, 32'h0, 32'h0, 3'd0, 32'h8000_000C, 32'h0, 0, 32'h0, 4'h0, 32'h0, 0, 32'h0};
    runTxn(predict(v), "post_reset_load");

    // Random traffic against the model.
    wl_pick = '{3'd1, 3'd2, 3'd4, 3'd1, 3'd2, 3'd4, 3'd3, 3'd0};
    for (int k = 0; k < 40; k++) begin
      v.wen = ($urandom_range(0, 2) == 0); v.ren = ($urandom_range(0, 2) == 0); v.iren = ($urandom_range(0, 1) == 0);
      v.waddr = 32'h8000_0000 + $urandom_range(0, 63); v.wdata = $urandom;
      v.wlen = wl_pick[$urandom_range(0, 7)];
      v.raddr = 32'h8000_0000 + $urandom_range(0, 63); v.iaddr = 32'h8000_0000 + $urandom_range(0, 63);
      runTxn(predict(v), $sformatf("rand%0d", k));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
